fifo_wr_arbiter: RTL
====================

Name: fifo_wr_arbiter

Overview:
- Round-robin scheduler that lets NUM_REQ producers share the single write port of the team's FIFO; clk drives the write side.
- Grants one requester at a time for a burst of up to MAX_BURST words, or until its end-of-packet marker.
- Drives the FIFO's wr_en and wr_data, and back-pressures on fifo_full.
- Sits directly in front of the FIFO write interface; the FIFO itself is unchanged.

Parameters:
- NUM_REQ, 4, number of requesters (legal 2..8).
- WIDTH, 8, data word width; matches the FIFO width.
- MAX_BURST, 4, maximum words accepted per grant (legal >= 1).
- IDX_W, $clog2(NUM_REQ), owner index width (derived).
- CNT_W, $clog2(MAX_BURST+1), burst counter width (derived).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rstn  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  req[i] high: requester i has a valid word on its data slice.
- req_data  input  NUM_REQ*WIDTH  requester i's word on bits [i*WIDTH +: WIDTH].
- req_last  input  NUM_REQ  marks requester i's current word as end-of-packet.
- ack  output  NUM_REQ  one-hot; ack[i] high: requester i's word is taken this cycle.
- fifo_full  input  1  FIFO full flag.
- fifo_wr_en  output  1  write strobe to the FIFO.
- fifo_wr_data  output  WIDTH  write data to the FIFO.
- busy  output  1  high while in the BURST state.
- owner  output  IDX_W  index of the current or most recent grantee.

Behaviour:
- Reset (async assert, rstn=0):
  - state=IDLE, cnt=0, owner=0.
  - last_owner=NUM_REQ-1, so requester 0 has top priority after reset.
  - ack=0, fifo_wr_en=0, fifo_wr_data=0, busy=0.
  - Reset mid-burst aborts the burst. No partial-burst recovery; the requester re-requests.
- States: IDLE and BURST.
- IDLE:
  - If req != 0, choose the first i with req[i]=1, scanning last_owner+1 upward modulo NUM_REQ.
  - Register owner=i, set cnt=0, go to BURST.
  - No ack is issued in IDLE, so arbitration latency is 1 cycle from req to first possible ack.
- BURST accept (combinational):
  - accept = req[owner] && !fifo_full.
  - ack[owner] = accept; all other ack bits are 0.
  - fifo_wr_en = accept.
  - fifo_wr_data = req_data slice of owner when accept, else 0.
  - busy = 1.
- BURST, on accept:
  - cnt increments.
  - Release if req_last[owner]=1, or if cnt == MAX_BURST-1 (this is the MAX_BURST-th word).
- BURST, req[owner]=0 (requester withdraws): release the same cycle; no word is written.
- BURST, fifo_full=1: stall. No ack, cnt holds, state holds. Burst resumes when full drops; no timeout.
- Release:
  - last_owner <= owner, state <= IDLE.
  - owner output holds its value until the next grant.
  - Minimum one idle cycle between bursts.
- Fairness: a requester that just released is lowest priority at the next arbitration. Worst-case wait is (NUM_REQ-1)*(MAX_BURST+1) accept cycles plus full stalls.
- Requester contract:
  - req[i] and its data are held stable until ack[i].
  - Changes on non-owner inputs are ignored.
- MAX_BURST=1: every accepted word releases.
- Simultaneous req_last and cnt limit on the same word: a single release, no double count.
- The FIFO's full flag is registered, so it can lag one cycle. The FIFO gates writes internally, and the arbiter relies on that gating. A word acked while the FIFO is actually full is the FIFO's responsibility to reject; the bench checks with a FIFO model that never drops.

Decomposition:
- Shared package fifo_arb_pkg:
  - state enum {IDLE, BURST}.
  - Default NUM_REQ, WIDTH, MAX_BURST constants.
  - A function rr_pick(req, last) returning the next index.
- One sub-module, rr_priority_pick: combinational round-robin search producing a found flag and an IDX_W index. It is reusable by the read-side scheduler.
- The FSM, counter and data mux stay in fifo_wr_arbiter.

Test Plan:
- Reset then req=4'b0001, data0=8'hA5, req_last[0]=0, fifo_full=0:
  - cycle 1 owner=0, busy=1; cycles 2..5 ack[0]=1, four writes of 8'hA5.
  - MAX_BURST release, then IDLE for one cycle, then re-grant to 0.
- req=4'b1111 held continuously with req_last=0: grant order 0,1,2,3,0. Each burst is exactly 4 writes, with one idle cycle between bursts.
- Owner 2, req_last[2]=1 on its 2nd word: exactly 2 writes, then release; next grant goes to 3 if req[3]=1, else 0.
- fifo_full=1 for 3 cycles after the owner's 1st word: ack=0 and wr_en=0 for those 3 cycles, cnt holds at 1. After full drops, 3 more writes, then release.
- Owner 1 drops req after 1 word: release that cycle, last_owner=1, with no write in the drop cycle.
- rstn pulsed low mid-burst (cnt=2): ack=0, fifo_wr_en=0 and busy=0 immediately (async). After release of reset with req=4'b1010, the first grant goes to 1.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types, default sizing and the round-robin search used by the FIFO
// write-side arbiter (and reusable by the read-side scheduler).
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_WIDTH     = 8;
  localparam int DEF_MAX_BURST = 4;

  // First set bit of req scanning upward from last+1, wrapping modulo n (n <= 8).
  // Iterates from the far end so the nearest candidate is the one left in pick.
  function automatic int unsigned rr_pick(input logic [7:0]  req,
                                          input int unsigned last,
                                          input int unsigned n);
    int unsigned idx;
    int unsigned pick;
    pick = 0;
    for (int unsigned k = 8; k >= 1; k--) begin
      if (k <= n) begin
        idx = last + k;
        if (idx >= n) idx = idx - n;
        if (((req >> idx) & 8'h01) != 8'h00) pick = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_priority_pick.sv
// Combinational round-robin search: finds the next requester after i_last.
module rr_priority_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  output logic               o_found,
  output logic [IDX_W-1:0]   o_idx
);

  assign o_found = |i_req;
  assign o_idx   = IDX_W'(rr_pick(8'(i_req), 32'(i_last), NUM_REQ));

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers,
// granting bursts of up to MAX_BURST words or until end-of-packet.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int IDX_W     = $clog2(NUM_REQ),
  parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]       req_last,
  output logic [NUM_REQ-1:0]       ack,
  input  logic                     fifo_full,
  output logic                     fifo_wr_en,
  output logic [WIDTH-1:0]         fifo_wr_data,
  output logic                     busy,
  output logic [IDX_W-1:0]         owner
);

  arb_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_owner;
  logic [IDX_W-1:0] r_last_owner;

  logic             w_found;
  logic [IDX_W-1:0] w_pick;
  logic             w_owner_req;
  logic             w_accept;
  logic             w_release;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .i_req   (req),
    .i_last  (r_last_owner),
    .o_found (w_found),
    .o_idx   (w_pick)
  );

  assign w_owner_req = req[r_owner];
  assign w_accept    = (r_state == BURST) && w_owner_req && !fifo_full;
  // Packet end and burst limit on the same word collapse into one release.
  assign w_release   = w_accept &&
                       (req_last[r_owner] || (r_cnt == CNT_W'(MAX_BURST - 1)));

  always_comb begin
    ack          = '0;
    fifo_wr_en   = w_accept;
    fifo_wr_data = '0;
    if (w_accept) begin
      ack[r_owner] = 1'b1;
      fifo_wr_data = req_data[r_owner*WIDTH +: WIDTH];
    end
  end

  assign busy  = (r_state == BURST);
  assign owner = r_owner;

  // Reset leaves the last grantee at NUM_REQ-1 so requester 0 wins first.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_owner      <= '0;
      r_last_owner <= IDX_W'(NUM_REQ - 1);
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_owner <= w_pick;
            r_cnt   <= '0;
            r_state <= BURST;
          end
        end
        BURST: begin
          if (!w_owner_req || w_release) begin
            r_last_owner <= r_owner;
            r_state      <= IDLE;
          end
          if (w_accept) r_cnt <= r_cnt + 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
